// File: rtl/spi_master.sv
// SPI mode-1 initiator: shifts one BIT_WIDTH frame out on MOSI, MSB first, with SCK from an internal divider.
// Optional MISO capture into rx_data is built only when SPI_MASTER_RX_EN is defined.
module spi_master #(
  parameter int BIT_WIDTH = 160,
  parameter int CLK_DIV   = 25
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [BIT_WIDTH-1:0] tx_data,
  output logic                 busy,
  output logic                 done,
  output logic [BIT_WIDTH-1:0] rx_data,
  output logic                 spi_sck,
  output logic                 spi_mosi,
  output logic                 spi_ss,
  input  logic                 spi_miso
);
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int BCW   = $clog2(BIT_WIDTH + 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_e;

  state_e               state_q, state_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic                 phase_q, phase_d;
  logic [BCW-1:0]       bit_q, bit_d;
  logic [BIT_WIDTH-1:0] sh_q, sh_d;
  logic                 fin_q, fin_d;
  logic                 busy_q, done_q, sck_q, mosi_q, ss_q;
  logic                 div_last, rise, fall;

  // phase_q = 0 is the SCK-high half of a bit period, 1 the low half.
  assign div_last = (div_q == DIV_W'(CLK_DIV - 1));
  assign rise     = (state_q == S_SHIFT) && !phase_q && (div_q == '0);
  assign fall     = (state_q == S_SHIFT) &&  phase_q && (div_q == '0);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    fin_d   = 1'b0;
    if (state_q != S_IDLE) div_d = div_last ? '0 : div_q + 1'b1;
    case (state_q)
      S_IDLE: if (start) begin
        sh_d    = tx_data;
        bit_d   = '0;
        phase_d = 1'b0;
        state_d = S_SETUP;
      end
      S_SETUP: if (div_last) state_d = S_SHIFT;
      S_SHIFT: begin
        if (fall) bit_d = bit_q + 1'b1;
        if (div_last) begin
          if (!phase_q) phase_d = 1'b1;
          else begin
            phase_d = 1'b0;
            sh_d    = sh_q << 1;
            if (bit_q == BCW'(BIT_WIDTH)) state_d = S_HOLD;
          end
        end
      end
      S_HOLD: if (div_last) state_d = S_GAP;
      S_GAP: if (div_last) begin
        state_d = S_IDLE;
        fin_d   = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      phase_q <= 1'b0;
      bit_q   <= '0;
      sh_q    <= '0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      fin_q   <= fin_d;
    end
  end

  // Pins are registered off the current state, so they trail the FSM by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      sck_q  <= 1'b0;
      mosi_q <= 1'b0;
      ss_q   <= 1'b1;
    end else begin
      busy_q <= (state_q != S_IDLE);
      done_q <= fin_q;
      sck_q  <= (state_q == S_SHIFT) && !phase_q;
      ss_q   <= !(state_q inside {S_SETUP, S_SHIFT, S_HOLD});
      if (rise)                                        mosi_q <= sh_q[BIT_WIDTH-1];
      else if (state_q == S_GAP || state_q == S_IDLE)  mosi_q <= 1'b0;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign spi_sck  = sck_q;
  assign spi_mosi = mosi_q;
  assign spi_ss   = ss_q;

`ifdef SPI_MASTER_RX_EN
  logic [BIT_WIDTH-1:0] rx_sh_q, rx_q, rx_shl;

  assign rx_shl = rx_sh_q << 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sh_q <= '0;
      rx_q    <= '0;
    end else begin
      if (fall)  rx_sh_q <= rx_shl | BIT_WIDTH'(spi_miso);
      if (fin_q) rx_q    <= rx_sh_q;
    end
  end

  assign rx_data = rx_q;
`else
  logic unused_miso;
  assign unused_miso = spi_miso;
  assign rx_data     = '0;
`endif

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: a 16-bit/CLK_DIV=2 instance driven by a mode-1 slave model,
// plus a default-parameter instance for the full-size frame timing.
module tb_spi_master;
  logic clk, rst_n;
  logic start, busy, done, spi_sck, spi_mosi, spi_ss, spi_miso;
  logic [15:0] tx_data, rx_data;
  logic b_start, b_busy, b_done, b_sck, b_mosi, b_ss, b_miso;
  logic [159:0] b_tx, b_rx;

  spi_master #(.BIT_WIDTH(16), .CLK_DIV(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .tx_data(tx_data), .busy(busy), .done(done),
    .rx_data(rx_data), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_ss(spi_ss), .spi_miso(spi_miso));

  spi_master u_big (
    .clk(clk), .rst_n(rst_n), .start(b_start), .tx_data(b_tx), .busy(b_busy), .done(b_done),
    .rx_data(b_rx), .spi_sck(b_sck), .spi_mosi(b_mosi), .spi_ss(b_ss), .spi_miso(b_miso));

`ifdef SPI_MASTER_RX_EN
  localparam logic [15:0] RX_EXP = 16'h3C5A;
`else
  localparam logic [15:0] RX_EXP = 16'h0000;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp, n_bad;
  int cyc, rises, dones, done_cyc, first_rise, sidx, ss_hi_run, min_ss_hi, mid_cyc;
  logic psck, pbusy, busy1, ss1, busy_pre, busy_done, seen_low;
  logic [15:0] mbits, rx_at_done, mid_data, slv_word;

  task automatic clear();
    cyc = 0; rises = 0; dones = 0; done_cyc = -1; first_rise = -1; sidx = 0;
    ss_hi_run = 0; min_ss_hi = 1000; mid_cyc = -1; seen_low = 1'b0;
    psck = spi_sck; pbusy = busy; mbits = '0; rx_at_done = 16'hDEAD;
    busy1 = 1'bx; ss1 = 1'bx; busy_pre = 1'bx; busy_done = 1'bx;
  endtask

  // One accepting edge (cycle 0); the watch loop then counts cycles from 1.
  task automatic send(input logic [15:0] d, input bit hold);
    tx_data = d; start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    tx_data = ~d;
  endtask

  task automatic watch(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (!psck && spi_sck) begin
        rises++;
        if (first_rise < 0) first_rise = cyc;
        spi_miso = slv_word[15 - sidx];
        sidx = (sidx + 1) % 16;
      end
      if (psck && !spi_sck) mbits = {mbits[14:0], spi_mosi};
      if (done) begin
        dones++; done_cyc = cyc; rx_at_done = rx_data; busy_pre = pbusy; busy_done = busy;
      end
      if (cyc == 1) begin busy1 = busy; ss1 = spi_ss; end
      if (spi_ss) ss_hi_run++;
      else begin
        if (seen_low && ss_hi_run > 0 && ss_hi_run < min_ss_hi) min_ss_hi = ss_hi_run;
        seen_low = 1'b1; ss_hi_run = 0;
      end
      if (cyc == mid_cyc) begin start = 1'b1; tx_data = mid_data; end
      else if (cyc == mid_cyc + 1) start = 1'b0;
      psck = spi_sck; pbusy = busy;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; tx_data = '0; spi_miso = 1'b0;
    b_start = 1'b0; b_tx = '0; b_miso = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (spi_ss !== 1'b1)   begin n_bad++; $display("FAIL reset_ss got %b want 1", spi_ss); end
    n_cmp++; if (spi_sck !== 1'b0)  begin n_bad++; $display("FAIL reset_sck got %b want 0", spi_sck); end
    n_cmp++; if (spi_mosi !== 1'b0) begin n_bad++; $display("FAIL reset_mosi got %b want 0", spi_mosi); end
    n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0)     begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
    n_cmp++; if (rx_data !== 16'h0) begin n_bad++; $display("FAIL reset_rx got %h want 0", rx_data); end
    n_cmp++; if (b_ss !== 1'b1)     begin n_bad++; $display("FAIL reset_big_ss got %b want 1", b_ss); end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    clear();
    send(16'hA5C3, 1'b0);
    watch(80);
    n_cmp++; if (busy1 !== 1'b1)      begin n_bad++; $display("FAIL basic_busy_c1 got %b want 1", busy1); end
    n_cmp++; if (ss1 !== 1'b0)        begin n_bad++; $display("FAIL basic_ss_c1 got %b want 0", ss1); end
    n_cmp++; if (first_rise != 3)     begin n_bad++; $display("FAIL basic_first_rise got %0d want 3", first_rise); end
    n_cmp++; if (rises != 16)         begin n_bad++; $display("FAIL basic_rises got %0d want 16", rises); end
    n_cmp++; if (mbits !== 16'hA5C3)  begin n_bad++; $display("FAIL basic_mosi got %h want a5c3", mbits); end
    n_cmp++; if (done_cyc != 71)      begin n_bad++; $display("FAIL basic_done_cyc got %0d want 71", done_cyc); end
    n_cmp++; if (dones != 1)          begin n_bad++; $display("FAIL basic_dones got %0d want 1", dones); end
    n_cmp++; if (busy_pre !== 1'b1)   begin n_bad++; $display("FAIL basic_busy_pre_done got %b want 1", busy_pre); end
    n_cmp++; if (busy_done !== 1'b0)  begin n_bad++; $display("FAIL basic_busy_at_done got %b want 0", busy_done); end
    n_cmp++; if (rx_at_done !== RX_EXP) begin n_bad++; $display("FAIL basic_rx got %h want %h", rx_at_done, RX_EXP); end
    n_cmp++; if (rx_data !== RX_EXP)  begin n_bad++; $display("FAIL basic_rx_held got %h want %h", rx_data, RX_EXP); end
    n_cmp++; if (spi_ss !== 1'b1)     begin n_bad++; $display("FAIL basic_ss_idle got %b want 1", spi_ss); end
  endtask

  task automatic test_ignore_start();
    clear();
    mid_cyc = 20; mid_data = 16'hFFFF;
    send(16'h0F96, 1'b0);
    watch(80);
    n_cmp++; if (rises != 16)         begin n_bad++; $display("FAIL ignore_rises got %0d want 16", rises); end
    n_cmp++; if (mbits !== 16'h0F96)  begin n_bad++; $display("FAIL ignore_mosi got %h want 0f96", mbits); end
    n_cmp++; if (dones != 1)          begin n_bad++; $display("FAIL ignore_dones got %0d want 1", dones); end
    n_cmp++; if (done_cyc != 71)      begin n_bad++; $display("FAIL ignore_done_cyc got %0d want 71", done_cyc); end
  endtask

  task automatic test_back_to_back();
    clear();
    send(16'h8001, 1'b1);
    watch(212);
    start = 1'b0;
    watch(1);
    n_cmp++; if (dones != 3)          begin n_bad++; $display("FAIL b2b_dones got %0d want 3", dones); end
    n_cmp++; if (done_cyc != 213)     begin n_bad++; $display("FAIL b2b_last_done got %0d want 213", done_cyc); end
    n_cmp++; if (rises != 48)         begin n_bad++; $display("FAIL b2b_rises got %0d want 48", rises); end
    n_cmp++; if (min_ss_hi < 3 || min_ss_hi > 100) begin n_bad++; $display("FAIL b2b_ss_gap got %0d want >=3", min_ss_hi); end
    watch(80);
    n_cmp++; if (dones != 3)          begin n_bad++; $display("FAIL b2b_no_extra got %0d want 3", dones); end
  endtask

  task automatic test_reset_mid();
    clear();
    send(16'hFFFF, 1'b0);
    watch(30);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (spi_ss !== 1'b1)   begin n_bad++; $display("FAIL rstmid_ss got %b want 1", spi_ss); end
    n_cmp++; if (spi_sck !== 1'b0)  begin n_bad++; $display("FAIL rstmid_sck got %b want 0", spi_sck); end
    n_cmp++; if (spi_mosi !== 1'b0) begin n_bad++; $display("FAIL rstmid_mosi got %b want 0", spi_mosi); end
    n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL rstmid_busy got %b want 0", busy); end
    n_cmp++; if (rx_data !== 16'h0) begin n_bad++; $display("FAIL rstmid_rx got %h want 0", rx_data); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clear();
    watch(80);
    n_cmp++; if (dones != 0)        begin n_bad++; $display("FAIL rstmid_no_done got %0d want 0", dones); end
    clear();
    send(16'h1234, 1'b0);
    watch(80);
    n_cmp++; if (mbits !== 16'h1234) begin n_bad++; $display("FAIL rstmid_after_mosi got %h want 1234", mbits); end
    n_cmp++; if (done_cyc != 71)    begin n_bad++; $display("FAIL rstmid_after_done got %0d want 71", done_cyc); end
    n_cmp++; if (rx_at_done !== RX_EXP) begin n_bad++; $display("FAIL rstmid_after_rx got %h want %h", rx_at_done, RX_EXP); end
  endtask

  task automatic test_defaults();
    int r, ones, bad_per, last_rise, dcyc, nd;
    logic ps;
    r = 0; ones = 0; bad_per = 0; last_rise = -1; dcyc = -1; nd = 0;
    b_tx = '1; b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0; b_tx = '0;
    ps = b_sck;
    for (int c = 1; c <= 8100; c++) begin
      @(posedge clk); #1;
      if (!ps && b_sck) begin
        r++;
        if (last_rise >= 0 && (c - last_rise) != 50) bad_per++;
        last_rise = c;
      end
      if (ps && !b_sck && b_mosi) ones++;
      if (b_done) begin nd++; dcyc = c; end
      ps = b_sck;
    end
    n_cmp++; if (r != 160)      begin n_bad++; $display("FAIL big_rises got %0d want 160", r); end
    n_cmp++; if (bad_per != 0)  begin n_bad++; $display("FAIL big_period got %0d bad want 0", bad_per); end
    n_cmp++; if (ones != 160)   begin n_bad++; $display("FAIL big_mosi_ones got %0d want 160", ones); end
    n_cmp++; if (dcyc != 8076)  begin n_bad++; $display("FAIL big_done_cyc got %0d want 8076", dcyc); end
    n_cmp++; if (nd != 1)       begin n_bad++; $display("FAIL big_dones got %0d want 1", nd); end
    n_cmp++; if (b_rx !== '0)   begin n_bad++; $display("FAIL big_rx got %h want 0", b_rx); end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    slv_word = 16'h3C5A;
    test_reset();
    test_basic();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_defaults();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
